// File: rtl/dual_port_ram_be.sv
// Dual-port RAM, one write port and one read port on one clock.
// Per-byte write enables, 1- or 2-cycle read latency, optional
// read-during-write bypass, and a clear sweep run after reset or on clr.
module dual_port_ram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int RD_LATENCY = 1,
   parameter int BYPASS     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [ADDR_WIDTH-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wbe,
   input  logic                      re,
   input  logic [ADDR_WIDTH-1:0]     raddr,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic                      rvalid,
   input  logic                      clr,
   output logic                      busy
);

   localparam int                  LP_NBYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_rvalid;

   logic                    w_sweep;
   logic                    w_last;
   logic                    w_wr_en;
   logic                    w_rd_en;
   logic                    w_clr_wr;
   logic                    w_rd_in_range;
   logic                    w_wr_in_range;
   logic [DATA_WIDTH-1:0]   w_rd_old;
   logic [DATA_WIDTH-1:0]   w_rd_merged;
   logic [DATA_WIDTH-1:0]   w_rd_word;
   logic                    w_out_vld;
   logic [DATA_WIDTH-1:0]   w_out_data;

   assign w_sweep       = (r_state == S_CLEAR);
   assign w_last        = (r_ptr == LP_LAST);
   assign w_wr_in_range = ({1'b0, waddr} < LP_DEPTH);
   assign w_rd_in_range = ({1'b0, raddr} < LP_DEPTH);
   // clr wins over a same-edge write; reads on that edge are still served
   assign w_wr_en       = we & ~w_sweep & ~clr & ~rst & w_wr_in_range;
   assign w_rd_en       = re & ~w_sweep & ~rst;
   assign w_clr_wr      = w_sweep & ~rst;

   // state register: reset always (re)starts the sweep
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_CLEAR;
      else     r_state <= w_state_nxt;
   end

   // next-state: IDLE leaves on clr, CLEAR ends after writing the last word
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (clr)    w_state_nxt = S_CLEAR;
         S_CLEAR: if (w_last) w_state_nxt = S_IDLE;
         default:             w_state_nxt = S_IDLE;
      endcase
   end

   // outputs: busy covers the reset-held period as well as the sweep
   always_comb begin
      busy = w_sweep | rst;
   end

   // sweep pointer: parked at 0 outside the sweep, steps once per clear write
   always_ff @(posedge clk) begin
      if (rst || !w_sweep) r_ptr <= '0;
      else                 r_ptr <= r_ptr + 1'b1;
   end

   // array write: clear sweep, otherwise byte-masked host write
   always_ff @(posedge clk) begin
      if (w_clr_wr) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_en) begin
         for (int b = 0; b < LP_NBYTES; b++)
            if (wbe[b]) r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // read word: out-of-range reads return zero; optional same-address bypass
   always_comb begin
      w_rd_old    = w_rd_in_range ? r_mem[raddr] : '0;
      w_rd_merged = w_rd_old;
      for (int b = 0; b < LP_NBYTES; b++)
         if (wbe[b]) w_rd_merged[8*b +: 8] = wdata[8*b +: 8];
      w_rd_word = w_rd_old;
      if (BYPASS != 0 && w_wr_en && waddr == raddr) w_rd_word = w_rd_merged;
   end

   // read data is captured at issue, so a later sweep cannot disturb it
   if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_s1_vld;
      logic [DATA_WIDTH-1:0] r_s1_data;

      // extra pipeline stage for the 2-cycle read
      always_ff @(posedge clk) begin
         if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
         end else begin
            r_s1_vld <= w_rd_en;
            if (w_rd_en) r_s1_data <= w_rd_word;
         end
      end
      assign w_out_vld  = r_s1_vld;
      assign w_out_data = r_s1_data;
   end else begin : g_lat1
      assign w_out_vld  = w_rd_en;
      assign w_out_data = w_rd_word;
   end

   // output stage: rvalid pulses per read, rdata holds between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_out_vld;
         if (w_out_vld) r_rdata <= w_out_data;
      end
   end

   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: three instances (latency/bypass/depth
// variants) share stimulus; a behavioural model predicts every output.
module tb_dual_port_ram_be;

   localparam int NI = 3;
   localparam int DEP [NI] = '{32, 32, 20};
   localparam int LAT [NI] = '{1, 2, 1};
   localparam int BYP [NI] = '{1, 0, 1};

   logic        clk;
   logic        rst, we, re, clr;
   logic [4:0]  waddr, raddr;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic [31:0] rd [NI];
   logic        rv [NI];
   logic        bz [NI];

   int n_chk  = 0;
   int n_fail = 0;

   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(1), .BYPASS(1)) u_dut0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]), .clr(clr), .busy(bz[0]));
   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(2), .BYPASS(0)) u_dut1 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]), .clr(clr), .busy(bz[1]));
   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20), .RD_LATENCY(1), .BYPASS(1)) u_dut2 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]), .clr(clr), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Memory per instance, remaining sweep cycles, and results keyed by the
   // edge on which they must appear at the output.
   logic [31:0] mm   [NI][32];
   int          sweep[NI];
   bit          slv  [NI][4];
   logic [31:0] sld  [NI][4];
   bit          e_v  [NI];
   logic [31:0] e_d  [NI];
   bit          m_init = 0;
   int          edge_n = 0;

   always @(posedge clk) begin
      for (int j = 0; j < NI; j++) begin
         if (rst) begin
            sweep[j] = DEP[j];
            for (int s = 0; s < 4; s++) slv[j][s] = 0;
            e_v[j] = 0;
            e_d[j] = 32'h0;
         end else if (m_init) begin
            bit          idle, rdo, wro;
            logic [31:0] val;
            idle = (sweep[j] == 0);
            rdo  = re && idle;
            wro  = we && idle && !clr && (int'(waddr) < DEP[j]);
            if (rdo) begin
               val = (int'(raddr) < DEP[j]) ? mm[j][raddr] : 32'h0;
               if (BYP[j] != 0 && wro && waddr == raddr)
                  for (int b = 0; b < 4; b++) if (wbe[b]) val[8*b +: 8] = wdata[8*b +: 8];
               slv[j][(edge_n + LAT[j] - 1) % 4] = 1;
               sld[j][(edge_n + LAT[j] - 1) % 4] = val;
            end
            if (wro)
               for (int b = 0; b < 4; b++) if (wbe[b]) mm[j][waddr][8*b +: 8] = wdata[8*b +: 8];
            if (!idle) begin
               sweep[j]--;
               if (sweep[j] == 0) for (int a = 0; a < 32; a++) mm[j][a] = 32'h0;
            end else if (clr) begin
               sweep[j] = DEP[j];
            end
            e_v[j] = slv[j][edge_n % 4];
            if (e_v[j]) e_d[j] = sld[j][edge_n % 4];
            slv[j][edge_n % 4] = 0;
         end
      end
      if (rst) m_init = 1;
      edge_n++;
   end

   // compare every cycle once the model has seen a reset
   always @(negedge clk) begin
      if (m_init) begin
         for (int j = 0; j < NI; j++) begin
            chk($sformatf("busy[%0d]", j),   32'(bz[j]), 32'(rst || sweep[j] > 0));
            chk($sformatf("rvalid[%0d]", j), 32'(rv[j]), 32'(e_v[j]));
            chk($sformatf("rdata[%0d]", j),  rd[j],      e_d[j]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      we = 0; re = 0; clr = 0; rst = 0;
      waddr = '0; raddr = '0; wdata = '0; wbe = '0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      we = 1; waddr = a; wdata = d; wbe = be;
      tick();
      we = 0;
   endtask

   // count cycles busy stays high on instance 0, bounded
   task automatic busy_len(input string nm, input bit rd_probe);
      int cnt;
      cnt = 0;
      while (bz[0] === 1'b1 && cnt < 100) begin
         cnt++;
         if (rd_probe) begin re = 1; raddr = 5'd3; end
         tick();
         if (rd_probe) chk({nm, "_no_rvalid"}, 32'(rv[0]), 32'd0);
      end
      chk(nm, cnt, 32'd32);
   endtask

   initial begin
      bit          vv [6];
      logic [31:0] dd [6];
      idle_in();
      rst = 1;
      tick(); tick(); tick();
      chk("reset_rdata",  rd[0], 32'h0);
      chk("reset_rvalid", 32'(rv[1]), 32'd0);
      chk("reset_busy",   32'(bz[0]), 32'd1);
      rst = 0;
      #1;
      busy_len("reset_busy_len", 0);

      // every word reads zero after the sweep
      for (int i = 0; i < 32; i++) begin
         re = 1; raddr = 5'(i);
         tick();
         chk("clear_read_vld",  32'(rv[0]), 32'd1);
         chk("clear_read_data", rd[0], 32'h0);
      end
      re = 0;

      // byte enables
      wr(5'd5, 32'hAABBCCDD, 4'hF);
      wr(5'd5, 32'h11223344, 4'b0101);
      re = 1; raddr = 5'd5;
      tick();
      re = 0;
      chk("be_lat1", rd[0], 32'hAA22CC44);
      tick();
      chk("be_lat2", rd[1], 32'hAA22CC44);

      // back-to-back reads with latency 2
      for (int i = 0; i < 4; i++) wr(5'(i + 1), 32'h10 + 32'(i), 4'hF);
      for (int i = 0; i < 6; i++) begin
         re = (i < 4); raddr = 5'(i + 1);
         tick();
         vv[i] = rv[1]; dd[i] = rd[1];
      end
      re = 0;
      chk("lat2_vld_pattern", {26'd0, vv[5], vv[4], vv[3], vv[2], vv[1], vv[0]}, 32'b011110);
      for (int i = 0; i < 4; i++) chk("lat2_data", dd[i + 1], 32'h10 + 32'(i));

      // read-during-write
      wr(5'd7, 32'h12345678, 4'hF);
      we = 1; waddr = 5'd7; wdata = 32'hFFFFFFFF; wbe = 4'b0011;
      re = 1; raddr = 5'd7;
      tick();
      we = 0; re = 0;
      chk("bypass1", rd[0], 32'h1234FFFF);
      tick();
      chk("bypass0", rd[1], 32'h12345678);

      // clr beats a same-edge write
      we = 1; waddr = 5'd3; wdata = 32'h0000DEAD; wbe = 4'hF; clr = 1;
      tick();
      we = 0; clr = 0;
      busy_len("clr_busy_len", 1);
      re = 1; raddr = 5'd3;
      tick();
      re = 0;
      chk("clr_addr3_vld",  32'(rv[0]), 32'd1);
      chk("clr_addr3_data", rd[0], 32'h0);

      // reset in the middle of a sweep restarts it
      for (int i = 0; i < 32; i++) wr(5'(i), 32'hA5000000 | 32'(i + 1), 4'hF);
      clr = 1;
      tick();
      clr = 0;
      repeat (10) tick();
      rst = 1;
      tick();
      rst = 0;
      #1;
      busy_len("rst_mid_busy_len", 0);
      for (int i = 0; i < 32; i++) begin
         re = 1; raddr = 5'(i);
         tick();
         chk("rst_mid_read", rd[0], 32'h0);
      end
      re = 0;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         we    = ($urandom_range(0, 1) == 1);
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         wbe   = 4'($urandom_range(0, 15));
         re    = ($urandom_range(0, 1) == 1);
         raddr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         clr   = ($urandom_range(0, 299) == 0);
         rst   = ($urandom_range(0, 799) == 0);
         tick();
      end
      idle_in();
      repeat (40) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
